// File: rtl/fc_in_buffer_if.sv
// Stream-in / parallel-out bundle between the previous FC layer, fc_in_buffer and the neuron array.
// master = upstream producer plus x consumer; slave = the buffer itself.
interface fc_in_buffer_if #(
    parameter int WIDTH    = 8,
    parameter int IN       = 128,
    parameter int IN_WIDTH = 23
);
    logic [IN_WIDTH-1:0]     s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic                    s_last;
    logic signed [WIDTH-1:0] x [0:IN-1];
    logic                    x_valid;
    logic                    x_ack;
    logic                    frame_err;

    modport master (
        output s_data, s_valid, s_last, x_ack,
        input  s_ready, x, x_valid, frame_err
    );

    modport slave (
        input  s_data, s_valid, s_last, x_ack,
        output s_ready, x, x_valid, frame_err
    );
endinterface

// File: rtl/fc_in_buffer.sv
// Requantizing input staging buffer for a fully-parallel FC layer: collects IN serial beats into x[].
// Optional macro FC_IN_SAT_CNT_EN adds sat_cnt, a per-frame count of positively saturated beats.
module fc_in_buffer #(
    parameter int WIDTH    = 8,
    parameter int IN       = 128,
    parameter int IN_WIDTH = 23,
    parameter int SHIFT    = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fc_in_buffer_if.slave            bus
`ifdef FC_IN_SAT_CNT_EN
    ,
    output logic [$clog2(IN+1)-1:0]  sat_cnt
`endif
);

    localparam int CW = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(IN - 1);

    // Half-LSB rounding constant; shifting then halving keeps SHIFT=0 at zero.
    localparam logic [IN_WIDTH:0] RND  = ({{IN_WIDTH{1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic [IN_WIDTH:0] MAXP = (IN_WIDTH+1)'((1 << (WIDTH - 1)) - 1);

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t                  state, state_nxt;
    logic                    armed;
    logic [CW-1:0]           cnt;
    logic                    err_q;
    logic signed [WIDTH-1:0] x_q [0:IN-1];

    logic                    accept;
    logic                    done;
    logic                    clear;
    logic                    s_ready_c;
    logic                    x_valid_c;

    logic [IN_WIDTH:0]       sum;
    logic [IN_WIDTH:0]       r;
    logic                    sat;
    logic [WIDTH-1:0]        q;

    // Requantize: negatives clamp to zero, positives round, shift and saturate.
    always_comb begin
        sum = {1'b0, bus.s_data} + RND;
        r   = sum >> SHIFT;
        sat = 1'b0;
        q   = '0;
        if (!bus.s_data[IN_WIDTH-1]) begin
            if (r > MAXP) begin
                sat = 1'b1;
                q   = MAXP[WIDTH-1:0];
            end else begin
                q   = r[WIDTH-1:0];
            end
        end
    end

    // armed holds s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready_c = 1'b0;
        x_valid_c = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        case (state)
            FILL: begin
                s_ready_c = armed;
                accept    = bus.s_valid && armed;
                if (accept && (cnt == CNT_LAST || bus.s_last)) begin
                    done      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                x_valid_c = 1'b1;
                if (bus.x_ack) begin
                    clear     = 1'b1;
                    state_nxt = FILL;
                end
            end
        endcase
    end

    // A frame is clean only when s_last arrives exactly on the final slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= '0;
            end
        end else if (clear) begin
            cnt   <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= '0;
            end
        end else if (accept) begin
            x_q[cnt] <= q;
            if (done) begin
                cnt   <= '0;
                err_q <= !(cnt == CNT_LAST && bus.s_last);
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end
    end

`ifdef FC_IN_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (clear) begin
            sat_cnt <= '0;
        end else if (accept && sat) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end
`endif

    assign bus.s_ready   = s_ready_c;
    assign bus.x_valid   = x_valid_c;
    assign bus.frame_err = err_q;
    assign bus.x         = x_q;

endmodule

// File: tb/tb_fc_in_buffer.sv
// Self-checking bench for fc_in_buffer: vector table, directed framing/reset sequences, random frames.
module tb_fc_in_buffer;

    localparam int WIDTH    = 8;
    localparam int IN       = 128;
    localparam int IN_WIDTH = 23;
    localparam int SHIFT    = 7;

    logic clk;
    logic rst_n;

    fc_in_buffer_if #(.WIDTH(WIDTH), .IN(IN), .IN_WIDTH(IN_WIDTH)) bus ();

`ifdef FC_IN_SAT_CNT_EN
    logic [$clog2(IN+1)-1:0] sat_cnt;
`endif

    fc_in_buffer #(
        .WIDTH(WIDTH), .IN(IN), .IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef FC_IN_SAT_CNT_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [IN_WIDTH-1:0] data;
        int                  exp_q;
        int                  exp_sat;
    } vec_t;

    vec_t vecs [0:9];
    int   tests;
    int   fails;
    int   exp_x [0:IN-1];
    int   exp_sat;
    int   mcnt;

    // Reference requantizer written straight from the arithmetic rules.
    function automatic int ref_q(input logic [IN_WIDTH-1:0] d);
        longint v;
        longint div;
        if (d[IN_WIDTH-1]) return 0;
        div = longint'(1) << SHIFT;
        v   = (longint'(d) + div / 2) / div;
        if (v > 127) return 127;
        return int'(v);
    endfunction

    function automatic bit ref_sat(input logic [IN_WIDTH-1:0] d);
        longint div;
        if (d[IN_WIDTH-1]) return 1'b0;
        div = longint'(1) << SHIFT;
        return ((longint'(d) + div / 2) / div) > 127;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < IN; i++) exp_x[i] = 0;
        exp_sat = 0;
        mcnt    = 0;
    endtask

    task automatic modelBeat(input logic [IN_WIDTH-1:0] d);
        exp_x[mcnt] = ref_q(d);
        if (ref_sat(d)) exp_sat++;
        mcnt++;
    endtask

    task automatic checkX(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < IN; i++) begin
            if (int'(bus.x[i]) != exp_x[i]) bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    // Present one beat and return 1ns after the edge that accepted it; s_valid stays high.
    task automatic applyStimulus(input logic [IN_WIDTH-1:0] d, input logic l);
        int n;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        n = 0;
        while (!bus.s_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            checkOutput("beat_timeout", 1, 0);
        end else begin
            @(posedge clk); #1;
        end
        modelBeat(d);
    endtask

    task automatic ackFrame();
        bus.s_valid = 1'b0;
        bus.x_ack   = 1'b1;
        @(posedge clk); #1;
        bus.x_ack   = 1'b0;
        resetModel();
    endtask

    task automatic checkFrame(input string name, input logic exp_err);
        checkOutput({name, "_x_valid"}, bus.x_valid, 1);
        checkOutput({name, "_s_ready"}, bus.s_ready, 0);
        checkOutput({name, "_frame_err"}, bus.frame_err, exp_err);
        checkX({name, "_x"});
`ifdef FC_IN_SAT_CNT_EN
        checkOutput({name, "_sat_cnt"}, sat_cnt, exp_sat);
`endif
    endtask

    function automatic logic [IN_WIDTH-1:0] randData();
        case ($urandom_range(0, 3))
            0:       return IN_WIDTH'($urandom);
            1:       return IN_WIDTH'($urandom_range(0, 20000));
            2:       return IN_WIDTH'($urandom_range(16250, 16400));
            default: return IN_WIDTH'($urandom_range(0, 300));
        endcase
    endfunction

    initial begin
        logic [IN_WIDTH-1:0] d;
        int                  len;
        logic                last;
        tests = 0;
        fails = 0;
        resetModel();

        vecs[0] = '{23'd63,       0,   0};
        vecs[1] = '{23'd64,       1,   0};
        vecs[2] = '{23'd191,      1,   0};
        vecs[3] = '{23'd192,      2,   0};
        vecs[4] = '{23'h3FFFFF,   127, 1};
        vecs[5] = '{23'h400000,   0,   0};
        vecs[6] = '{23'd16319,    127, 0};
        vecs[7] = '{23'd16320,    127, 1};
        vecs[8] = '{23'h7FFFFF,   0,   0};
        vecs[9] = '{23'd0,        0,   0};

        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.x_ack   = 1'b0;
        rst_n       = 1'b0;

        #12;
        checkOutput("rst_s_ready", bus.s_ready, 0);
        checkOutput("rst_x_valid", bus.x_valid, 0);
        checkOutput("rst_frame_err", bus.frame_err, 0);
        checkX("rst_x");
        @(negedge clk) rst_n = 1'b1;
        #1;
        checkOutput("rel_s_ready_pre_edge", bus.s_ready, 0);
        @(posedge clk); #1;
        checkOutput("rel_s_ready", bus.s_ready, 1);

        // Ramp frame: x[k] = k.
        for (int k = 0; k < IN; k++) begin
            applyStimulus(IN_WIDTH'(k << 7), k == IN - 1);
            if (k == IN - 2) checkOutput("ramp_not_early", bus.x_valid, 0);
        end
        bus.s_valid = 1'b0;
        checkOutput("ramp_x100", bus.x[100], 100);
        checkFrame("ramp", 1'b0);
        ackFrame();
        checkOutput("ack_x_valid", bus.x_valid, 0);
        checkOutput("ack_s_ready", bus.s_ready, 1);
        checkOutput("ack_frame_err", bus.frame_err, 0);
        checkX("ack_x_clear");

        // Single-beat frames through the requantization table.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].data, 1'b1);
            bus.s_valid = 1'b0;
            checkOutput($sformatf("vec%0d_q", i), bus.x[0], vecs[i].exp_q);
            checkOutput($sformatf("vec%0d_x1", i), bus.x[1], 0);
            checkOutput($sformatf("vec%0d_err", i), bus.frame_err, 1);
`ifdef FC_IN_SAT_CNT_EN
            checkOutput($sformatf("vec%0d_sat", i), sat_cnt, vecs[i].exp_sat);
`endif
            ackFrame();
        end

        // Early s_last on beat 9.
        for (int k = 0; k < 10; k++) applyStimulus(23'd256, k == 9);
        bus.s_valid = 1'b0;
        checkOutput("early_x9", bus.x[9], 2);
        checkOutput("early_x10", bus.x[10], 0);
        checkFrame("early", 1'b1);
        ackFrame();

        // Backpressure: s_valid never drops across the frame and while FULL.
        for (int k = 0; k < IN; k++) applyStimulus(randData(), k == IN - 1);
        bus.s_data = IN_WIDTH'(5 << 7);
        bus.s_last = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checkOutput("bp_s_ready", bus.s_ready, 0);
            @(posedge clk); #1;
        end
        checkFrame("bp", 1'b0);
        bus.x_ack = 1'b1;
        @(posedge clk); #1;
        bus.x_ack = 1'b0;
        resetModel();
        checkOutput("bp_ack_x_valid", bus.x_valid, 0);
        checkOutput("bp_ack_s_ready", bus.s_ready, 1);
        checkX("bp_ack_x_clear");
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        modelBeat(IN_WIDTH'(5 << 7));
        checkOutput("bp_next_x0", bus.x[0], 5);
        checkFrame("bp_next", 1'b1);
        ackFrame();

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 50; k++) applyStimulus(randData() | 23'd512, 1'b0);
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput("arst_x_valid", bus.x_valid, 0);
        checkOutput("arst_frame_err", bus.frame_err, 0);
        checkOutput("arst_s_ready", bus.s_ready, 0);
        checkX("arst_x");
`ifdef FC_IN_SAT_CNT_EN
        checkOutput("arst_sat_cnt", sat_cnt, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < IN; k++) applyStimulus(randData(), k == IN - 1);
        bus.s_valid = 1'b0;
        checkFrame("post_rst", 1'b0);
        ackFrame();

        // s_last never asserted.
        for (int k = 0; k < IN; k++) applyStimulus(randData(), 1'b0);
        bus.s_valid = 1'b0;
        checkFrame("nolast", 1'b1);
        ackFrame();
        checkOutput("nolast_ack_err", bus.frame_err, 0);

        // Random frames with idle gaps and delayed acknowledges.
        for (int f = 0; f < 15; f++) begin
            len  = ($urandom_range(0, 2) == 0) ? IN : $urandom_range(1, IN);
            last = (len < IN) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                d = randData();
                applyStimulus(d, (k == len - 1) ? last : 1'b0);
            end
            bus.s_valid = 1'b0;
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            checkFrame($sformatf("rand%0d", f), !(len == IN && last));
            ackFrame();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
